// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the intersection demand-capture path.
package traffic_pkg;

  // Width of the debounce counter; supports DEBOUNCE_CYCLES up to 15.
  localparam int DEBOUNCE_W = 4;

  // Wait age at which a pending demand is flagged overdue. Kept equal to the
  // intersection's 25-cycle service bound so both sides agree on "late".
  localparam int OVERDUE_LIMIT_DEFAULT = 25;

  // Next debounce count: restart on a low level, count up to the target, then hold.
  function automatic logic [DEBOUNCE_W-1:0] debounce_next(
    input logic                  level,
    input logic [DEBOUNCE_W-1:0] cnt,
    input logic [DEBOUNCE_W-1:0] target
  );
    logic [DEBOUNCE_W-1:0] nxt;
    if (!level) begin
      nxt = '0;
    end else if (cnt < target) begin
      nxt = cnt + DEBOUNCE_W'(1);
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/demand_channel.sv
// One demand channel: synchronise and debounce a raw request line, hold it as a
// sticky request until the matching green, and track how long it has waited.
module demand_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int AGE_WIDTH       = 8,
  parameter int OVERDUE_LIMIT   = OVERDUE_LIMIT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 raw_i,
  input  logic                 green_i,
  output logic                 req_o,
  output logic [AGE_WIDTH-1:0] age_o,
  output logic                 overdue_o
);

  localparam logic [DEBOUNCE_W-1:0] DB_TARGET = DEBOUNCE_W'(DEBOUNCE_CYCLES);
  localparam logic [AGE_WIDTH-1:0]  AGE_MAX   = '1;
  localparam logic [31:0]           LIMIT     = 32'(OVERDUE_LIMIT);

  logic                  s1_q, s2_q;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  accept_q, accept_d;
  logic                  req_q, req_d;
  logic [AGE_WIDTH-1:0]  age_q, age_d;
  logic                  overdue_q, overdue_d;

  // Next-state logic: debounce, accept pulse, sticky request, age and overdue.
  always_comb begin
    cnt_d     = debounce_next(s2_q, cnt_q, DB_TARGET);
    // Pulse only on the transition into the target count, so a held input
    // fires once and must drop low before it can fire again.
    accept_d  = (cnt_d == DB_TARGET) && (cnt_q != DB_TARGET);
    req_d     = req_q;
    age_d     = '0;
    overdue_d = 1'b0;

    // Green clears first: a press during its own green counts as served.
    if (green_i) begin
      req_d = 1'b0;
    end else if (accept_q) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end

    // Age starts at 0 on the first pending cycle and drops to 0 with the request.
    if (req_d && req_q) begin
      age_d = (age_q == AGE_MAX) ? age_q : age_q + AGE_WIDTH'(1);
    end else begin
      age_d = '0;
    end

    if (req_d && req_q) begin
      overdue_d = (32'(age_q) >= LIMIT);
    end else begin
      overdue_d = 1'b0;
    end
  end

  // State registers, including the two-flop synchroniser on the raw input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      accept_q  <= 1'b0;
      req_q     <= 1'b0;
      age_q     <= '0;
      overdue_q <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      accept_q  <= accept_d;
      req_q     <= req_d;
      age_q     <= age_d;
      overdue_q <= overdue_d;
    end
  end

  assign req_o     = req_q;
  assign age_o     = age_q;
  assign overdue_o = overdue_q;

endmodule

// File: rtl/demand_capture.sv
// Demand capture for the intersection: a pedestrian channel and a turn-lane
// channel, each an independent demand_channel. Wiring only.
module demand_capture
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int AGE_WIDTH       = 8,
  parameter int OVERDUE_LIMIT   = OVERDUE_LIMIT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pedestrian_button_raw,
  input  logic                 turn_sensor_raw,
  input  logic                 pedestrian_green,
  input  logic                 turn_green,
  output logic                 pedestrian_button,
  output logic                 turn_sensor,
  output logic [AGE_WIDTH-1:0] ped_wait_age,
  output logic [AGE_WIDTH-1:0] turn_wait_age,
  output logic                 ped_overdue,
  output logic                 turn_overdue
);

  demand_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .AGE_WIDTH      (AGE_WIDTH),
    .OVERDUE_LIMIT  (OVERDUE_LIMIT)
  ) u_ped (
    .clk_i    (clock),
    .rst_i    (reset),
    .raw_i    (pedestrian_button_raw),
    .green_i  (pedestrian_green),
    .req_o    (pedestrian_button),
    .age_o    (ped_wait_age),
    .overdue_o(ped_overdue)
  );

  demand_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .AGE_WIDTH      (AGE_WIDTH),
    .OVERDUE_LIMIT  (OVERDUE_LIMIT)
  ) u_turn (
    .clk_i    (clock),
    .rst_i    (reset),
    .raw_i    (turn_sensor_raw),
    .green_i  (turn_green),
    .req_o    (turn_sensor),
    .age_o    (turn_wait_age),
    .overdue_o(turn_overdue)
  );

endmodule

// File: tb/tb_demand_capture.sv
// Self-checking bench for demand_capture: directed scenarios plus a randomized
// run against a behavioural model built from sample-history windows.
module tb_demand_capture;

  localparam int D   = 3;
  localparam int LIM = 25;
  localparam int HL  = 12;

  logic clock = 1'b0;
  logic reset;
  logic ped_raw, turn_raw, ped_green, turn_green;

  logic       ped_btn, turn_sns, ped_ovd, turn_ovd;
  logic [7:0] ped_age, turn_age;
  logic       ped_btn4, turn_sns4, ped_ovd4, turn_ovd4;
  logic [3:0] ped_age4, turn_age4;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = pedestrian, 1 = turn.
  bit hist [2][HL];
  bit acc_prev [2];
  bit m_req [2];
  int m_age [2];
  int m_age4 [2];
  bit m_ovd [2];
  bit m_ovd4 [2];

  demand_capture #(.DEBOUNCE_CYCLES(D), .AGE_WIDTH(8), .OVERDUE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .pedestrian_button_raw(ped_raw), .turn_sensor_raw(turn_raw),
    .pedestrian_green(ped_green), .turn_green(turn_green),
    .pedestrian_button(ped_btn), .turn_sensor(turn_sns),
    .ped_wait_age(ped_age), .turn_wait_age(turn_age),
    .ped_overdue(ped_ovd), .turn_overdue(turn_ovd)
  );

  demand_capture #(.DEBOUNCE_CYCLES(D), .AGE_WIDTH(4), .OVERDUE_LIMIT(LIM)) dut4 (
    .clock(clock), .reset(reset),
    .pedestrian_button_raw(ped_raw), .turn_sensor_raw(turn_raw),
    .pedestrian_green(ped_green), .turn_green(turn_green),
    .pedestrian_button(ped_btn4), .turn_sensor(turn_sns4),
    .ped_wait_age(ped_age4), .turn_wait_age(turn_age4),
    .ped_overdue(ped_ovd4), .turn_overdue(turn_ovd4)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int m = 0; m < HL; m++) hist[c][m] = 1'b0;
      acc_prev[c] = 1'b0; m_req[c] = 1'b0; m_age[c] = 0; m_age4[c] = 0;
      m_ovd[c] = 1'b0; m_ovd4[c] = 1'b0;
    end
  endtask

  // Model of one clock edge. A demand is accepted when the raw samples taken
  // 2..D+1 edges ago were all high and the one before that run was low.
  task automatic model_edge();
    bit raw_v [2];
    bit grn_v [2];
    bit acc_now, req_new;
    raw_v[0] = ped_raw;   raw_v[1] = turn_raw;
    grn_v[0] = ped_green; grn_v[1] = turn_green;
    if (reset) begin
      model_clear();
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int m = HL - 1; m > 0; m--) hist[c][m] = hist[c][m-1];
        hist[c][0] = raw_v[c];
        acc_now = 1'b1;
        for (int m = 2; m <= D + 1; m++) if (!hist[c][m]) acc_now = 1'b0;
        if (hist[c][D+2]) acc_now = 1'b0;
        req_new = grn_v[c] ? 1'b0 : (acc_prev[c] ? 1'b1 : m_req[c]);
        m_ovd[c]  = req_new && m_req[c] && (m_age[c] >= LIM);
        m_ovd4[c] = req_new && m_req[c] && (m_age4[c] >= LIM);
        if (req_new && m_req[c]) begin
          m_age[c]  = (m_age[c] + 1 > 255) ? 255 : m_age[c] + 1;
          m_age4[c] = (m_age4[c] + 1 > 15) ? 15 : m_age4[c] + 1;
        end else begin
          m_age[c] = 0; m_age4[c] = 0;
        end
        m_req[c]    = req_new;
        acc_prev[c] = acc_now;
      end
    end
  endtask

  // Advance one clock; outputs are inspected at the following falling edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; ped_raw = 1'b0; turn_raw = 1'b0; ped_green = 1'b0; turn_green = 1'b0;
    model_clear();
    step(); step();
    checks++;
    if ({ped_btn, turn_sns, ped_ovd, turn_ovd, ped_age, turn_age} !== 20'd0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", {ped_btn, turn_sns, ped_ovd, turn_ovd, ped_age, turn_age});
    end
    reset = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      checks++;
      if ({ped_btn, turn_sns, ped_ovd, turn_ovd, ped_age, turn_age, ped_btn4, turn_sns4, ped_age4, turn_age4} !== 30'd0) begin
        errors++; $display("FAIL idle_outputs: cycle %0d got nonzero outputs, expected 0", n);
      end
    end
  endtask

  task automatic test_ped_latency();
    ped_raw = 1'b1;
    for (int n = 1; n <= D + 5; n++) begin
      step();
      checks++;
      if (ped_btn !== (n >= D + 3)) begin
        errors++; $display("FAIL ped_latency: edge %0d got %0b expected %0b", n, ped_btn, (n >= D + 3));
      end
    end
    for (int n = 0; n < 15; n++) step();
    ped_green = 1'b1;
    step();
    ped_green = 1'b0;
    checks++;
    if (ped_btn !== 1'b0 || ped_age !== 8'd0) begin
      errors++; $display("FAIL ped_green_clear: got req %0b age %0d expected req 0 age 0", ped_btn, ped_age);
    end
    for (int n = 0; n < 8; n++) step();
    checks++;
    if (ped_btn !== 1'b0) begin
      errors++; $display("FAIL ped_held_no_reaccept: got %0b expected 0", ped_btn);
    end
    ped_raw = 1'b0;
    for (int n = 0; n < 4; n++) step();
  endtask

  task automatic test_glitch();
    turn_raw = 1'b1; step(); step(); turn_raw = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if (turn_sns !== 1'b0) begin
        errors++; $display("FAIL turn_glitch: cycle %0d got %0b expected 0", n, turn_sns);
      end
    end
    turn_raw = 1'b1;
    for (int n = 1; n <= D + 5; n++) begin
      step();
      if (n == D) turn_raw = 1'b0;
      checks++;
      if (turn_sns !== (n >= D + 3)) begin
        errors++; $display("FAIL turn_pulse: edge %0d got %0b expected %0b", n, turn_sns, (n >= D + 3));
      end
    end
    turn_green = 1'b1; step(); turn_green = 1'b0; step();
  endtask

  task automatic test_age_overdue();
    int guard;
    ped_raw = 1'b1;
    for (int n = 0; n < D; n++) step();
    ped_raw = 1'b0;
    guard = 0;
    while (ped_btn !== 1'b1 && guard < 10) begin step(); guard++; end
    checks++;
    if (ped_btn !== 1'b1) begin
      errors++; $display("FAIL age_setup: got req %0b expected 1 within 10 cycles", ped_btn);
    end
    for (int i = 0; i <= 40; i++) begin
      checks++;
      if (ped_age !== 8'(i) || ped_ovd !== (i >= LIM + 1)) begin
        errors++; $display("FAIL ped_age8: i %0d got age %0d ovd %0b expected %0d %0b", i, ped_age, ped_ovd, i, (i >= LIM + 1));
      end
      checks++;
      if (ped_age4 !== 4'((i > 15) ? 15 : i) || ped_ovd4 !== 1'b0) begin
        errors++; $display("FAIL ped_age4: i %0d got age %0d ovd %0b expected %0d 0", i, ped_age4, ped_ovd4, (i > 15) ? 15 : i);
      end
      step();
    end
    ped_green = 1'b1; step(); ped_green = 1'b0;
    checks++;
    if (ped_btn !== 1'b0 || ped_ovd !== 1'b0 || ped_age !== 8'd0) begin
      errors++; $display("FAIL ovd_clear: got req %0b ovd %0b age %0d expected 0 0 0", ped_btn, ped_ovd, ped_age);
    end
    step();
  endtask

  task automatic test_clear_wins();
    ped_raw = 1'b1;
    for (int n = 0; n < D + 2; n++) step();
    ped_green = 1'b1; step(); ped_green = 1'b0;
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (ped_btn !== 1'b0) begin
        errors++; $display("FAIL clear_wins: cycle %0d got %0b expected 0", n, ped_btn);
      end
      step();
    end
    ped_raw = 1'b0;
    for (int n = 0; n < 4; n++) step();
  endtask

  task automatic test_back_to_back();
    ped_raw = 1'b1; turn_raw = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == D + 1) begin ped_raw = 1'b0; turn_raw = 1'b0; end
      checks++;
      if (ped_btn !== (n >= D + 3) || turn_sns !== (n >= D + 3) ||
          ped_age !== turn_age || ped_age !== 8'((n >= D + 3) ? n - D - 3 : 0)) begin
        errors++; $display("FAIL both_channels: edge %0d got %0b %0b ages %0d %0d expected req %0b age %0d",
                           n, ped_btn, turn_sns, ped_age, turn_age, (n >= D + 3), (n >= D + 3) ? n - D - 3 : 0);
      end
    end
    ped_green = 1'b1; turn_green = 1'b1; step(); ped_green = 1'b0; turn_green = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    int guard;
    ped_raw = 1'b1;
    guard = 0;
    while (!(m_req[0] && m_age[0] == 12) && guard < 40) begin step(); guard++; end
    checks++;
    if (ped_age !== 8'd12) begin
      errors++; $display("FAIL reset_mid_setup: got age %0d expected 12", ped_age);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ped_btn, ped_age, ped_ovd} !== 10'd0) begin
      errors++; $display("FAIL reset_async: got req %0b age %0d expected 0 0", ped_btn, ped_age);
    end
    model_clear();
    step(); step();
    reset = 1'b0;
    for (int n = 1; n <= D + 5; n++) begin
      step();
      checks++;
      if (ped_btn !== (n >= D + 3)) begin
        errors++; $display("FAIL reset_restart: edge %0d got %0b expected %0b", n, ped_btn, (n >= D + 3));
      end
    end
    ped_raw = 1'b0; ped_green = 1'b1; step(); ped_green = 1'b0; step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3, 0) == 0) ped_raw  = ~ped_raw;
      if ($urandom_range(3, 0) == 0) turn_raw = ~turn_raw;
      ped_green  = ($urandom_range(47, 0) == 0);
      turn_green = ($urandom_range(47, 0) == 0);
      step();
      checks++;
      if (ped_btn !== m_req[0] || ped_age !== 8'(m_age[0]) || ped_ovd !== m_ovd[0]) begin
        errors++; $display("FAIL rand_ped: cycle %0d got %0b/%0d/%0b expected %0b/%0d/%0b",
                           n, ped_btn, ped_age, ped_ovd, m_req[0], m_age[0], m_ovd[0]);
      end
      checks++;
      if (turn_sns !== m_req[1] || turn_age !== 8'(m_age[1]) || turn_ovd !== m_ovd[1]) begin
        errors++; $display("FAIL rand_turn: cycle %0d got %0b/%0d/%0b expected %0b/%0d/%0b",
                           n, turn_sns, turn_age, turn_ovd, m_req[1], m_age[1], m_ovd[1]);
      end
      checks++;
      if (ped_btn4 !== m_req[0] || ped_age4 !== 4'(m_age4[0]) || ped_ovd4 !== m_ovd4[0] ||
          turn_sns4 !== m_req[1] || turn_age4 !== 4'(m_age4[1]) || turn_ovd4 !== m_ovd4[1]) begin
        errors++; $display("FAIL rand_age4: cycle %0d got %0d/%0d expected %0d/%0d",
                           n, ped_age4, turn_age4, m_age4[0], m_age4[1]);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_ped_latency();
    test_glitch();
    test_age_overdue();
    test_clear_wins();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
